// File: rtl/fnd_scan_ctrl_if.sv
// Display controller bus: digit/decoration inputs from the datapath and
// the active-low FND pin outputs.
interface fnd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] i_digits;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   i_blink_mask;
  logic                    i_blank_lz;
  logic [2:0]              i_bright;
  logic [NUM_DIGITS-1:0]   fnd_digit;
  logic [7:0]              fnd_data;

  modport master (
    output i_digits, i_dp, i_blink_mask, i_blank_lz, i_bright,
    input  fnd_digit, fnd_data
  );
  modport slave (
    input  i_digits, i_dp, i_blink_mask, i_blank_lz, i_bright,
    output fnd_digit, fnd_data
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: hex decode, dp, blink,
// leading-zero blanking and PWM brightness, with per-frame input snapshot.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic            clk,
  input  logic            reset,
  fnd_scan_ctrl_if.slave  bus
);
  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = (DIV > 1)        ? $clog2(DIV)        : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW   = (BDIV > 1)       ? $clog2(BDIV)       : 1;

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           bcnt;
  logic                    phase;
  logic [4*NUM_DIGITS-1:0] s_digits;
  logic [NUM_DIGITS-1:0]   s_dp, s_blink;
  logic                    s_lz;
  logic [2:0]              s_bright;

  logic                    tick, frame_end, bwrap;
  logic [NUM_DIGITS:0]     upper_zero;
  logic [3:0]              nib;
  logic [7:0]              seg;
  logic [31:0]             thr;
  logic                    dark;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  assign tick      = (pre == PW'(DIV - 1));
  assign frame_end = tick && (idx == IW'(NUM_DIGITS - 1));
  assign bwrap     = (bcnt == BW'(BDIV - 1));

  // upper_zero[k]: every snapshot nibble from k up to the leftmost digit is zero
  assign upper_zero[NUM_DIGITS] = 1'b1;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    assign upper_zero[k] = (s_digits[4*k +: 4] == 4'd0) && upper_zero[k+1];
  end

  always_comb begin
    nib  = s_digits[{idx, 2'b00} +: 4];
    seg  = hex7(nib);
    seg[7] = ~s_dp[idx];
    // DIV is a multiple of 8, so ((bright+1)*DIV)>>3 reduces to an exact product
    thr  = (32'(s_bright) + 32'd1) * 32'(DIV / 8);
    dark = 1'b0;
    if (s_lz && (idx != '0) && upper_zero[idx]) dark = 1'b1;
    if (s_blink[idx] && phase)                  dark = 1'b1;
    if (32'(pre) >= thr)                        dark = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre           <= '0;
      idx           <= '0;
      bcnt          <= '0;
      phase         <= 1'b0;
      s_digits      <= '0;
      s_dp          <= '0;
      s_blink       <= '0;
      s_lz          <= 1'b0;
      s_bright      <= '0;
      bus.fnd_digit <= '1;
      bus.fnd_data  <= 8'hFF;
    end else begin
      pre  <= tick ? '0 : pre + PW'(1);
      if (tick) idx <= frame_end ? '0 : idx + IW'(1);
      bcnt <= bwrap ? '0 : bcnt + BW'(1);
      if (bwrap) phase <= ~phase;
      if (frame_end) begin
        s_digits <= bus.i_digits;
        s_dp     <= bus.i_dp;
        s_blink  <= bus.i_blink_mask;
        s_lz     <= bus.i_blank_lz;
        s_bright <= bus.i_bright;
      end
      bus.fnd_digit <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
      bus.fnd_data  <= dark ? 8'hFF : seg;
    end
  end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomized bench for fnd_scan_ctrl against a time-indexed behavioural model.
module tb_fnd_scan_ctrl;
  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int BDIV = 40;
  localparam int F    = DIV * N;

  typedef struct {
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp;
    logic [N-1:0]   mask;
    logic           lz;
    logic [2:0]     bright;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0, failures = 0;
  int   e = 0;
  snap_t msnap;
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  fnd_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  fnd_scan_ctrl #(.NUM_DIGITS(N), .CLK_HZ(800), .SCAN_HZ(100), .BLINK_HZ(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at e=%0d: got %h expected %h", tag, e, got, exp);
    end
  endtask

  function automatic snap_t zero_snap();
    snap_t s;
    s.digits = '0; s.dp = '0; s.mask = '0; s.lz = 1'b0; s.bright = '0;
    return s;
  endfunction

  function automatic snap_t cur_inputs();
    snap_t s;
    s.digits = bus.i_digits; s.dp = bus.i_dp; s.mask = bus.i_blink_mask;
    s.lz = bus.i_blank_lz; s.bright = bus.i_bright;
    return s;
  endfunction

  // Output after edge c+1 as a function of elapsed cycles c since reset release.
  function automatic void model_out(input int c, input snap_t s,
                                    output logic [3:0] dg, output logic [7:0] dt);
    int  pre, idx, ph, nib;
    bit  dark, allz;
    pre  = c % DIV;
    idx  = (c / DIV) % N;
    ph   = (c / BDIV) % 2;
    dark = 0;
    if (s.lz && idx > 0) begin
      allz = 1;
      for (int k = idx; k < N; k++) if (((s.digits >> (4*k)) & 16'hF) != 0) allz = 0;
      if (allz) dark = 1;
    end
    if (s.mask[idx] && ph == 1) dark = 1;
    if (pre >= (((int'(s.bright) + 1) * DIV) >> 3)) dark = 1;
    nib = int'((s.digits >> (4*idx)) & 16'hF);
    dt  = seg_tab[nib];
    if (s.dp[idx]) dt[7] = 1'b0;
    dg  = ~(4'b0001 << idx);
    if (dark) begin dg = 4'hF; dt = 8'hFF; end
  endfunction

  task automatic run(input int n);
    logic [3:0] xd;
    logic [7:0] xs;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); e++; #1;
      model_out(e - 1, msnap, xd, xs);
      chk("fnd_digit", 32'(bus.fnd_digit), 32'(xd));
      chk("fnd_data",  32'(bus.fnd_data),  32'(xs));
      if (e % F == 0) msnap = cur_inputs();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_digit", 32'(bus.fnd_digit), 32'hF);
      chk("rst_data",  32'(bus.fnd_data),  32'hFF);
    end
    reset = 1'b0;
    e = 0;
    msnap = zero_snap();
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] m,
                        input logic lz, input logic [2:0] b);
    bus.i_digits = d; bus.i_dp = dp; bus.i_blink_mask = m;
    bus.i_blank_lz = lz; bus.i_bright = b;
  endtask

  initial begin
    set_in(16'h1234, 4'b0, 4'b0, 1'b0, 3'd7);
    do_reset(3);
    // first frame shows the zero snapshot, then 1234; switch to ABCD mid frame 2
    run(F + 16);
    set_in(16'hABCD, 4'b0, 4'b0, 1'b0, 3'd7);
    run(16 + 2*F);
    set_in(16'h1234, 4'b0100, 4'b0, 1'b0, 3'd7); run(2*F);
    set_in(16'h0005, 4'b0, 4'b0, 1'b1, 3'd7);    run(2*F);
    set_in(16'h0000, 4'b0, 4'b0, 1'b1, 3'd7);    run(2*F);
    set_in(16'h0105, 4'b0, 4'b0, 1'b1, 3'd7);    run(2*F);
    set_in(16'h1234, 4'b0, 4'b0001, 1'b0, 3'd7); run(6*F);
    set_in(16'h1234, 4'b0, 4'b0, 1'b0, 3'd3);    run(2*F);
    set_in(16'h1234, 4'b0, 4'b0, 1'b0, 3'd0);    run(2*F);
    // reset mid-frame, then resume
    set_in(16'h5678, 4'b0, 4'b0, 1'b0, 3'd7);    run(13);
    do_reset(2);
    run(F + 5);
    for (int r = 0; r < 60; r++) begin
      set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) bus.i_digits = 16'($urandom_range(0, 255));
      run($urandom_range(1, 50));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
